// File: rtl/intctl7_pkg.sv
// Shared types and constants for the seven-source interrupt controller.
package intctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2,
        SERV = 2'd3
    } intctl_state_t;

    localparam int unsigned NSRC        = 7;
    localparam logic [2:0]  ID_SPURIOUS = 3'd0;

    function automatic logic [7:0] make_vec(input logic [7:0] base, input logic [2:0] id);
        return base | {5'd0, id};
    endfunction

endpackage

// File: rtl/intctl7_if.sv
// Request/mask inputs, encoder loop and CPU handshake of intctl7.
interface intctl7_if;
    import intctl_pkg::*;

    logic [NSRC:1] irq;
    logic          mask_we;
    logic [NSRC:1] mask_d;
    logic [NSRC:1] pend;
    logic [2:0]    id;
    logic          intr;
    logic          inta;
    logic          eoi;
    logic [7:0]    vec;
    logic          vec_e;
    logic          busy;
    logic [2:0]    isr;

    modport slave (
        input  irq, mask_we, mask_d, id, inta, eoi,
        output pend, intr, vec, vec_e, busy, isr
    );

    modport master (
        output irq, mask_we, mask_d, id, inta, eoi,
        input  pend, intr, vec, vec_e, busy, isr
    );

endinterface

// File: rtl/intctl7_rise7.sv
// Seven-bit rising-edge detector; a line high out of reset counts as an edge.
module rise7
    import intctl_pkg::*;
(
    input  logic          c_i,
    input  logic          r_i,
    input  logic [NSRC:1] d_i,
    output logic [NSRC:1] rise_o
);

    logic [NSRC:1] prev_q;

    always_ff @(posedge c_i) begin
        if (r_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/intctl7.sv
// Seven-source interrupt controller with single-level int/inta/eoi handshake.
module intctl7
    import intctl_pkg::*;
#(
    parameter logic [7:0] VBASE = 8'h40
) (
    input  logic       c_i,
    input  logic       r_i,
    intctl7_if.slave   bus_if
);

    intctl_state_t state_q;
    logic [NSRC:1] pending_q;
    logic [NSRC:1] pending_d;
    logic [NSRC:1] mask_q;
    logic [NSRC:1] rise;
    logic [NSRC:1] clr;
    logic [2:0]    isr_q;
    logic [7:0]    vec_q;
    logic          int_q;
    logic          vec_e_q;
    logic          busy_q;
    logic          accept;

    rise7 u_rise7 (
        .c_i    (c_i),
        .r_i    (r_i),
        .d_i    (bus_if.irq),
        .rise_o (rise)
    );

    assign bus_if.pend = pending_q & ~mask_q;
    assign accept      = (state_q == PEND) && (bus_if.pend != '0) && bus_if.inta;

    // A fresh edge on the acknowledged line wins over its clear.
    always_comb begin
        clr = '0;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            clr[i] = accept && (bus_if.id == 3'(i));
        end
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge c_i) begin
        if (r_i) begin
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            pending_q <= pending_d;
            if (bus_if.mask_we) begin
                mask_q <= bus_if.mask_d;
            end
        end
    end

    always_ff @(posedge c_i) begin
        if (r_i) begin
            state_q <= IDLE;
            isr_q   <= ID_SPURIOUS;
            int_q   <= 1'b0;
            vec_q   <= '0;
            vec_e_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            vec_e_q <= 1'b0;
            vec_q   <= '0;
            unique case (state_q)
                IDLE: begin
                    if (bus_if.pend != '0) begin
                        state_q <= PEND;
                        int_q   <= 1'b1;
                    end
                end
                PEND: begin
                    if (bus_if.pend == '0) begin
                        state_q <= IDLE;
                        int_q   <= 1'b0;
                    end else if (bus_if.inta) begin
                        state_q <= ACK;
                        int_q   <= 1'b0;
                        vec_e_q <= 1'b1;
                        vec_q   <= make_vec(VBASE, bus_if.id);
                        if (bus_if.id != ID_SPURIOUS) begin
                            isr_q <= bus_if.id;
                        end
                    end
                end
                ACK: begin
                    if (isr_q != ID_SPURIOUS) begin
                        state_q <= SERV;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SERV: begin
                    if (bus_if.eoi) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        isr_q   <= ID_SPURIOUS;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.intr  = int_q;
    assign bus_if.vec   = vec_q;
    assign bus_if.vec_e = vec_e_q;
    assign bus_if.busy  = busy_q;
    assign bus_if.isr   = isr_q;

endmodule

// File: tb/tb_intctl7.sv
// Directed scoreboard bench for intctl7 with a lowest-index-wins encoder model.
module tb_intctl7;
    import intctl_pkg::*;

    logic c;
    logic r;
    logic force0;
    logic [2:0] enc_id;
    int unsigned nvec;
    int unsigned nfail;
    logic [7:0] exp_q[$];

    intctl7_if ifc ();

    intctl7 #(.VBASE(8'h40)) dut (
        .c_i    (c),
        .r_i    (r),
        .bus_if (ifc)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // Stand-in for the upstream priority7 encoder: lowest pending index wins.
    always_comb begin
        enc_id = '0;
        for (int i = 7; i >= 1; i--) begin
            if (ifc.pend[i]) enc_id = 3'(i);
        end
        if (force0) enc_id = '0;
    end
    assign ifc.id = enc_id;

    function automatic logic [7:1] onehot(input int i);
        logic [7:1] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_int"},   {7'd0, ifc.intr},  8'h00);
        chk({tag, "_vec_e"}, {7'd0, ifc.vec_e}, 8'h00);
        chk({tag, "_vec"},   ifc.vec,           8'h00);
        chk({tag, "_busy"},  {7'd0, ifc.busy},  8'h00);
        chk({tag, "_pend"},  {1'b0, ifc.pend},  8'h00);
        chk({tag, "_isr"},   {5'd0, ifc.isr},   8'h00);
    endtask

    task automatic do_inta(input logic [7:0] v, input logic [2:0] sid);
        exp_q.push_back(v);
        ifc.inta = 1'b1;
        step();
        ifc.inta = 1'b0;
        chk("ack_vec_e", {7'd0, ifc.vec_e}, 8'h01);
        if (exp_q.size() > 0) chk("ack_vec", ifc.vec, exp_q.pop_front());
        chk("ack_int", {7'd0, ifc.intr}, 8'h00);
        step();
        chk("post_vec_e", {7'd0, ifc.vec_e}, 8'h00);
        chk("post_vec", ifc.vec, 8'h00);
        chk("post_busy", {7'd0, ifc.busy}, (sid != 3'd0) ? 8'h01 : 8'h00);
        chk("post_isr", {5'd0, ifc.isr}, {5'd0, sid});
    endtask

    task automatic do_eoi();
        ifc.eoi = 1'b1;
        step();
        ifc.eoi = 1'b0;
        chk("eoi_busy", {7'd0, ifc.busy}, 8'h00);
        chk("eoi_isr", {5'd0, ifc.isr}, 8'h00);
        chk("eoi_int", {7'd0, ifc.intr}, 8'h00);
    endtask

    task automatic write_mask(input logic [7:1] m);
        ifc.mask_we = 1'b1;
        ifc.mask_d  = m;
        step();
        ifc.mask_we = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nfail = 0;
        force0 = 1'b0;
        r = 1'b1;
        ifc.irq = '0;
        ifc.mask_we = 1'b0;
        ifc.mask_d = '0;
        ifc.inta = 1'b0;
        ifc.eoi = 1'b0;
        step();
        step();
        chk_reset("rst");
        r = 1'b0;

        // Single request, full handshake.
        write_mask('0);
        ifc.irq = onehot(3);
        step();
        ifc.irq = '0;
        chk("t_int", {7'd0, ifc.intr}, 8'h00);
        chk("t_pend", {1'b0, ifc.pend}, {1'b0, onehot(3)});
        step();
        chk("t1_int", {7'd0, ifc.intr}, 8'h01);
        do_inta(8'h43, 3'd3);
        do_eoi();

        // Two simultaneous requests, lower index first.
        ifc.irq = onehot(5) | onehot(2);
        step();
        ifc.irq = '0;
        step();
        chk("two_int", {7'd0, ifc.intr}, 8'h01);
        do_inta(8'h42, 3'd2);
        chk("two_pend", {1'b0, ifc.pend}, {1'b0, onehot(5)});
        do_eoi();
        step();
        chk("two_reint", {7'd0, ifc.intr}, 8'h01);
        do_inta(8'h45, 3'd5);
        do_eoi();

        // Masked request held until unmasked.
        write_mask('1);
        ifc.irq = onehot(4);
        step();
        ifc.irq = '0;
        step();
        step();
        chk("msk_int", {7'd0, ifc.intr}, 8'h00);
        write_mask('0);
        chk("unmsk_pend", {1'b0, ifc.pend}, {1'b0, onehot(4)});
        step();
        chk("unmsk_int", {7'd0, ifc.intr}, 8'h01);
        do_inta(8'h44, 3'd4);
        do_eoi();

        // Mask write while in PEND, then a spurious acknowledge.
        ifc.irq = onehot(6);
        step();
        ifc.irq = '0;
        step();
        chk("p6_int", {7'd0, ifc.intr}, 8'h01);
        write_mask('1);
        chk("pm_pend", {1'b0, ifc.pend}, 8'h00);
        step();
        chk("pm_int_drop", {7'd0, ifc.intr}, 8'h00);
        write_mask('0);
        step();
        chk("pm_int_back", {7'd0, ifc.intr}, 8'h01);
        force0 = 1'b1;
        do_inta(8'h40, 3'd0);
        force0 = 1'b0;
        chk("spur_pend", {1'b0, ifc.pend}, {1'b0, onehot(6)});
        step();
        chk("spur_reint", {7'd0, ifc.intr}, 8'h01);
        do_inta(8'h46, 3'd6);

        // New edge during service waits for eoi.
        ifc.irq = onehot(1);
        step();
        ifc.irq = '0;
        step();
        chk("serv_int", {7'd0, ifc.intr}, 8'h00);
        chk("serv_pend", {1'b0, ifc.pend}, {1'b0, onehot(1)});
        do_eoi();
        step();
        chk("serv_reint", {7'd0, ifc.intr}, 8'h01);

        // Reset during the vector cycle.
        ifc.inta = 1'b1;
        step();
        ifc.inta = 1'b0;
        chk("rack_vec_e", {7'd0, ifc.vec_e}, 8'h01);
        chk("rack_vec", ifc.vec, 8'h41);
        r = 1'b1;
        step();
        chk_reset("rmid");

        // Line high through reset is seen as an edge once reset drops.
        ifc.irq = onehot(7);
        step();
        r = 1'b0;
        write_mask('0);
        ifc.irq = '0;
        chk("hold_pend", {1'b0, ifc.pend}, {1'b0, onehot(7)});
        chk("hold_int0", {7'd0, ifc.intr}, 8'h00);
        step();
        chk("hold_int1", {7'd0, ifc.intr}, 8'h01);
        do_inta(8'h47, 3'd7);
        do_eoi();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
